// File: rtl/ok_wire_pkg.sv
// Shared host-interface constants for okHost wire endpoints: address/data widths,
// the Wire Out address window and okEH field offsets.
package ok_wire_pkg;

  localparam int unsigned OK_ADDR_W = 8;
  localparam int unsigned OK_DATA_W = 32;

  localparam logic [OK_ADDR_W-1:0] WIREOUT_ADDR_MIN = 8'h20;
  localparam logic [OK_ADDR_W-1:0] WIREOUT_ADDR_MAX = 8'h3F;

  // okEH bus layout: read data occupies the low field, ready flag sits above it
  localparam int unsigned OKEH_W          = 65;
  localparam int unsigned OKEH_DATA_LSB   = 0;
  localparam int unsigned OKEH_DATA_MSB   = OKEH_DATA_LSB + OK_DATA_W - 1;
  localparam int unsigned OKEH_READY_BIT  = 32;

  typedef logic [OK_ADDR_W-1:0] ok_addr_t;
  typedef logic [OK_DATA_W-1:0] ok_data_t;

endpackage

// File: rtl/ok_wire_out_chan.sv
// One Wire Out channel: snapshot register, optional sticky-OR accumulator and
// change detection against the previous sample.
module ok_wire_out_chan #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          STICKY = 1'b0
) (
  input  logic             ti_clk,
  input  logic             ti_reset_n,
  input  logic             ti_wireupdate,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] hold,
  output logic             stat
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] prev;
  logic             chg;
  logic             diff;

  assign diff = (din != prev);

  always_ff @(posedge ti_clk or negedge ti_reset_n) begin
    if (!ti_reset_n) begin
      hold <= '0;
      acc  <= '0;
      prev <= '0;
      chg  <= 1'b0;
      stat <= 1'b0;
    end else begin
      prev <= din;
      // Same-cycle bits and changes are folded into this snapshot, then cleared
      if (ti_wireupdate) begin
        hold <= STICKY ? (acc | din) : din;
        acc  <= '0;
        stat <= chg | diff;
        chg  <= 1'b0;
      end else begin
        acc  <= STICKY ? (acc | din) : '0;
        chg  <= chg | diff;
      end
    end
  end

endmodule

// File: rtl/ok_wire_out_bank.sv
// Multi-channel Wire Out bank with atomic snapshot, change-status word and,
// when WIRE_OUT_TIMESTAMP_EN is defined, a captured free-running timestamp.
module ok_wire_out_bank
  import ok_wire_pkg::*;
#(
  parameter int unsigned  N_CH        = 4,
  parameter int unsigned  WIDTH       = 32,
  parameter logic [7:0]   BASE_ADDR   = 8'h20,
  parameter logic [31:0]  STICKY_MASK = '0
) (
  input  logic                  ti_clk,
  input  logic                  ti_reset_n,
  input  logic                  ti_wireupdate,
  input  logic [7:0]            ti_addr,
  input  logic [N_CH*WIDTH-1:0] ep_datain,
  output logic [31:0]           ep_dataout,
  output logic                  ep_hit
);

`ifdef WIRE_OUT_TIMESTAMP_EN
  localparam int unsigned TS_WORDS = 1;
`else
  localparam int unsigned TS_WORDS = 0;
`endif

  localparam ok_addr_t STAT_ADDR = BASE_ADDR + 8'(N_CH);

  if (N_CH < 1 || N_CH > 32) begin : g_bad_nch
    $error("ok_wire_out_bank: N_CH out of range 1..32");
  end
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("ok_wire_out_bank: WIDTH out of range 1..32");
  end
  if (BASE_ADDR < WIREOUT_ADDR_MIN ||
      int'(BASE_ADDR) + int'(N_CH) + int'(TS_WORDS) > int'(WIREOUT_ADDR_MAX)) begin : g_bad_addr
    $error("ok_wire_out_bank: address range outside Wire Out window");
  end

  logic [WIDTH-1:0] hold [N_CH];
  logic [N_CH-1:0]  stat_hold;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    ok_wire_out_chan #(
      .WIDTH  (WIDTH),
      .STICKY (STICKY_MASK[g])
    ) u_chan (
      .ti_clk        (ti_clk),
      .ti_reset_n    (ti_reset_n),
      .ti_wireupdate (ti_wireupdate),
      .din           (ep_datain[g*WIDTH +: WIDTH]),
      .hold          (hold[g]),
      .stat          (stat_hold[g])
    );
  end

`ifdef WIRE_OUT_TIMESTAMP_EN
  localparam ok_addr_t TS_ADDR = STAT_ADDR + 8'd1;

  ok_data_t ts_cnt;
  ok_data_t ts_hold;

  always_ff @(posedge ti_clk or negedge ti_reset_n) begin
    if (!ti_reset_n) begin
      ts_cnt  <= '0;
      ts_hold <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (ti_wireupdate) ts_hold <= ts_cnt;
    end
  end
`endif

  always_comb begin
    ep_dataout = '0;
    ep_hit     = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (ti_addr == BASE_ADDR + 8'(i)) begin
        ep_hit     = 1'b1;
        ep_dataout = OK_DATA_W'(hold[i]);
      end
    end
    if (ti_addr == STAT_ADDR) begin
      ep_hit     = 1'b1;
      ep_dataout = OK_DATA_W'(stat_hold);
    end
`ifdef WIRE_OUT_TIMESTAMP_EN
    if (ti_addr == TS_ADDR) begin
      ep_hit     = 1'b1;
      ep_dataout = ts_hold;
    end
`endif
  end

endmodule

// File: tb/tb_ok_wire_out_bank.sv
// Directed self-checking bench for ok_wire_out_bank (N_CH=4, BASE=8'h20, ch1 sticky).
module tb_ok_wire_out_bank;

  logic         ti_clk;
  logic         ti_reset_n;
  logic         ti_wireupdate;
  logic [7:0]   ti_addr;
  logic [31:0]  din [4];
  logic [127:0] ep_datain;
  logic [31:0]  ep_dataout;
  logic         ep_hit;

  int checks;
  int failures;

  assign ep_datain = {din[3], din[2], din[1], din[0]};

  ok_wire_out_bank #(
    .N_CH        (4),
    .WIDTH       (32),
    .BASE_ADDR   (8'h20),
    .STICKY_MASK (32'h0000_0002)
  ) dut (
    .ti_clk        (ti_clk),
    .ti_reset_n    (ti_reset_n),
    .ti_wireupdate (ti_wireupdate),
    .ti_addr       (ti_addr),
    .ep_datain     (ep_datain),
    .ep_dataout    (ep_dataout),
    .ep_hit        (ep_hit)
  );

  initial ti_clk = 1'b0;
  always #5 ti_clk = ~ti_clk;

  task automatic tick();
    @(posedge ti_clk);
    #1;
  endtask

  task automatic set_din(input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3);
    din[0] = d0; din[1] = d1; din[2] = d2; din[3] = d3;
  endtask

  task automatic pulse_update();
    ti_wireupdate = 1'b1;
    tick();
    ti_wireupdate = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_zero;
    exp_zero = '0;
    ti_reset_n = 1'b0;
    ti_wireupdate = 1'b0;
    set_din('0, '0, '0, '0);
    repeat (3) tick();
    ti_reset_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      ti_addr = 8'h20 + 8'(i);
      #1;
      checks++;
      if (ep_dataout !== exp_zero || ep_hit !== 1'b1) begin
        failures++;
        $display("FAIL reset_read addr=%h got data=%h hit=%b want data=%h hit=1",
                 ti_addr, ep_dataout, ep_hit, exp_zero);
      end
    end
    ti_addr = 8'h10;
    #1;
    checks++;
    if (ep_dataout !== 32'h0 || ep_hit !== 1'b0) begin
      failures++;
      $display("FAIL reset_miss addr=10 got data=%h hit=%b want data=0 hit=0", ep_dataout, ep_hit);
    end
  endtask

  task automatic test_snapshot();
    logic [31:0] exp [5];
    set_din(32'hA5A5_0001, '0, '0, 32'h1234_5678);
    pulse_update();
    set_din(32'hFFFF_FFFF, '0, '0, 32'h0);
    tick();
    exp[0] = 32'hA5A5_0001; exp[1] = '0; exp[2] = '0; exp[3] = 32'h1234_5678;
    exp[4] = 32'h0000_0009;
    for (int i = 0; i < 5; i++) begin
      ti_addr = 8'h20 + 8'(i);
      #1;
      checks++;
      if (ep_dataout !== exp[i] || ep_hit !== 1'b1) begin
        failures++;
        $display("FAIL snapshot addr=%h got data=%h hit=%b want data=%h hit=1",
                 ti_addr, ep_dataout, ep_hit, exp[i]);
      end
    end
    ti_addr = 8'h25;
    #1;
`ifndef WIRE_OUT_TIMESTAMP_EN
    checks++;
    if (ep_dataout !== 32'h0 || ep_hit !== 1'b0) begin
      failures++;
      $display("FAIL ts_addr_disabled got data=%h hit=%b want data=0 hit=0", ep_dataout, ep_hit);
    end
`endif
  endtask

  task automatic test_sticky();
    set_din('0, '0, '0, '0);
    tick();
    pulse_update();
    din[1] = 32'h1;   tick();
    din[1] = 32'h4;   tick();
    din[1] = 32'h100; tick();
    din[1] = 32'h0;
    pulse_update();
    ti_addr = 8'h21;
    #1;
    checks++;
    if (ep_dataout !== 32'h0000_0105) begin
      failures++;
      $display("FAIL sticky_or got %h want 00000105", ep_dataout);
    end
    ti_addr = 8'h24;
    #1;
    checks++;
    if (ep_dataout !== 32'h0000_0002) begin
      failures++;
      $display("FAIL sticky_status got %h want 00000002", ep_dataout);
    end
    tick();
    pulse_update();
    ti_addr = 8'h21;
    #1;
    checks++;
    if (ep_dataout !== 32'h0) begin
      failures++;
      $display("FAIL sticky_cleared got %h want 00000000", ep_dataout);
    end
  endtask

  task automatic test_status();
    din[2] = 32'h7; tick();
    din[2] = 32'h0; tick();
    pulse_update();
    ti_addr = 8'h24;
    #1;
    checks++;
    if (ep_dataout !== 32'h0000_0004) begin
      failures++;
      $display("FAIL status_toggle got %h want 00000004", ep_dataout);
    end
    pulse_update();
    #1;
    checks++;
    if (ep_dataout !== 32'h0) begin
      failures++;
      $display("FAIL status_b2b_clear got %h want 00000000", ep_dataout);
    end
    din[2] = 32'h5;
    pulse_update();
    ti_addr = 8'h24;
    #1;
    checks++;
    if (ep_dataout !== 32'h0000_0004) begin
      failures++;
      $display("FAIL status_coincident got %h want 00000004", ep_dataout);
    end
    ti_addr = 8'h22;
    #1;
    checks++;
    if (ep_dataout !== 32'h5) begin
      failures++;
      $display("FAIL hold_coincident got %h want 00000005", ep_dataout);
    end
    pulse_update();
    ti_addr = 8'h24;
    #1;
    checks++;
    if (ep_dataout !== 32'h0) begin
      failures++;
      $display("FAIL status_once got %h want 00000000", ep_dataout);
    end
    ti_addr = 8'h22;
    #1;
    checks++;
    if (ep_dataout !== 32'h5) begin
      failures++;
      $display("FAIL hold_stable got %h want 00000005", ep_dataout);
    end
  endtask

  task automatic test_reset_mid_accum();
    set_din(32'h3, 32'hF0, 32'h5, '0);
    tick();
    din[1] = 32'h0F;
    tick();
    ti_reset_n = 1'b0;
    #2;
    set_din('0, '0, '0, '0);
    tick();
    ti_reset_n = 1'b1;
    tick();
    pulse_update();
    for (int i = 0; i < 5; i++) begin
      ti_addr = 8'h20 + 8'(i);
      #1;
      checks++;
      if (ep_dataout !== 32'h0 || ep_hit !== 1'b1) begin
        failures++;
        $display("FAIL reset_mid addr=%h got data=%h hit=%b want data=0 hit=1",
                 ti_addr, ep_dataout, ep_hit);
      end
    end
  endtask

`ifdef WIRE_OUT_TIMESTAMP_EN
  task automatic test_timestamp();
    logic [31:0] t0;
    ti_addr = 8'h25;
    pulse_update();
    #1;
    checks++;
    if (ep_hit !== 1'b1) begin
      failures++;
      $display("FAIL ts_hit got %b want 1", ep_hit);
    end
    t0 = ep_dataout;
    repeat (99) tick();
    pulse_update();
    #1;
    checks++;
    if (ep_dataout - t0 !== 32'd100) begin
      failures++;
      $display("FAIL ts_delta got %0d want 100", ep_dataout - t0);
    end
    force dut.ts_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.ts_cnt;
    ti_wireupdate = 1'b1;
    tick();
    checks++;
    if (ep_dataout !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL ts_prewrap got %h want ffffffff", ep_dataout);
    end
    tick();
    ti_wireupdate = 1'b0;
    checks++;
    if (ep_dataout !== 32'h0) begin
      failures++;
      $display("FAIL ts_wrap got %h want 00000000", ep_dataout);
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    ti_addr = 8'h00;
    test_reset();
    test_snapshot();
    test_sticky();
    test_status();
    test_reset_mid_accum();
`ifdef WIRE_OUT_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
